result_trace_buffer: RTL and testbench
======================================

Name: result_trace_buffer

Overview:
- Captures the datapath `result` bus into a timestamped trace FIFO, so benches and debug logic can drain results through a ready/valid port.
- Replaces ad-hoc printing of every clock edge.
- Parametrised in data width, depth and timestamp width.
- Supports capture-every-cycle and capture-on-change modes.
- Sits beside `datapath`, fed by its `result` output.

Parameters:
- DATA_W, 32, width of the captured result word.
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- CYC_W, 16, width of the free-running cycle stamp.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture and cycle counting active when 1.
- mode  in  1  0 = capture every enabled cycle; 1 = capture only when the value changes.
- clear  in  1  synchronous flush of FIFO, counter and flags.
- result_in  in  DATA_W  datapath result sampled each clock.
- rd_valid  out  1  FIFO non-empty; head entry presented.
- rd_ready  in  1  consumer accepts the head when rd_valid && rd_ready.
- rd_data  out  DATA_W  captured result at the head.
- rd_cycle  out  CYC_W  cycle stamp of the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: one or more captures were dropped.

Behaviour:
- Reset (rst_n=0, async) drives all outputs and state to zero:
  - rd_valid=0, rd_data=0, rd_cycle=0, count=0, overflow=0.
  - cycle counter=0, last_valid=0.
- Cycle counter:
  - Increments by 1 on every clock with enable=1.
  - Wraps from 2^CYC_W-1 to 0 without flagging.
  - Holds when enable=0.
- Capture request (push_req) at a clock edge, with enable=1:
  - mode=0: request every cycle.
  - mode=1: request when last_valid=0 or result_in != last_value.
- Entry and change tracking:
  - Each entry is {cycle counter value before increment, result_in}.
  - On any accepted push, last_value is updated to result_in and last_valid is set to 1.
  - last_value is not updated on a dropped push.
- FIFO is first-word-fall-through:
  - rd_valid = (count != 0).
  - rd_data/rd_cycle show the head combinationally from storage.
  - rd_data/rd_cycle are unchanged while rd_valid=0.
- Pop occurs when rd_valid && rd_ready. The head advances on the next edge.
- Latency: a capture at edge N is visible on rd_valid/rd_data after edge N.
- Full, push without pop: the new entry is dropped and overflow is set. Existing contents are untouched.
- Full, push with pop in the same cycle: both succeed and count stays at DEPTH. overflow is not set.
- Empty, push with rd_ready=1: no pop, because rd_valid=0. Push succeeds and count becomes 1.
- Pointers are log2(DEPTH) bits and wrap naturally. count tracks occupancy explicitly.
- clear=1 has priority over push and pop in the same cycle. On the next edge:
  - count=0, pointers=0, cycle counter=0, overflow=0, last_valid=0.
  - Storage contents are don't-care.
- Mode switch mid-run takes effect on the same cycle. last_value is retained across the switch.
- Reset asserted mid-drain: immediate, asynchronous return to reset values. Drained data is lost.
- rd_ready is ignored while rd_valid=0.

Decomposition:
- Shared package `trace_pkg`:
  - Constants MODE_ALL=1'b0 and MODE_CHANGE=1'b1.
  - Localparam helper for the pointer width, $clog2(DEPTH).
- Sub-module `sync_fifo`:
  - Parametrised WIDTH/DEPTH, async active-low reset, FWFT output.
  - Exposes push, pop, full, empty and count.
  - Instantiated with WIDTH = CYC_W+DATA_W.
- `result_trace_buffer` holds only:
  - The cycle counter.
  - Change-detect registers.
  - Drop/overflow logic.
  - The clear fan-out.

Test Plan:
- Reset, then mode=0, enable=1, result_in=5,6,7 on three edges, rd_ready=0:
  - count=3, rd_valid=1.
  - Head rd_data=5, rd_cycle=0.
  - Then rd_ready=1 for 3 cycles pops 5/0, 6/1, 7/2; count=0, rd_valid=0.
- mode=1, result_in held at 9 for 4 cycles, then 12 for 2 cycles:
  - Exactly 2 entries: {0,9} and {4,12}.
  - overflow=0.
- DEPTH=16, mode=0, rd_ready=0, 20 enabled cycles:
  - count=16 and overflow=1.
  - Head is the cycle-0 entry; the cycle-15 entry is the last stored.
  - With the FIFO full, push and pop together: count stays 16, and the new entry is stamped with the current cycle.
- clear=1 asserted together with a push and rd_ready=1 while count=8:
  - Next cycle: count=0, overflow=0, rd_valid=0.
  - Next capture is stamped cycle 0.
- CYC_W=4, mode=0, 18 enabled cycles with the FIFO continuously drained:
  - Stamps run 0..15, 0, 1 (wrap with no flag).
  - enable=0 for 3 cycles: no pushes, counter frozen.
- rst_n pulled low asynchronously mid-cycle with count=5:
  - All outputs zero immediately, before the next edge.
  - After release, operation resumes with cycle stamp 0.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared capture-mode constants and sizing helper for the result trace buffer.
package trace_pkg;

    localparam logic MODE_ALL    = 1'b0;
    localparam logic MODE_CHANGE = 1'b1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with explicit occupancy count and synchronous clear.
// Storage is reset so the head reads zero out of reset.
module sync_fifo
    import trace_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (PTR_W+1)'(DEPTH);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the slot being written.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = clear_i ? '0 : wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = clear_i ? '0 : rd_ptr_q + PTR_W'(do_pop);
        count_d  = clear_i ? '0 : count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/result_trace_buffer.sv
// result_trace_buffer: captures the datapath result bus into a cycle-stamped FWFT trace FIFO.
// Holds the cycle counter, change detection, drop/overflow tracking and clear fan-out.
module result_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     mode,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        result_in,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [CYC_W-1:0]         rd_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [DATA_W-1:0] last_value_q, last_value_d;
    logic              last_valid_q, last_valid_d;
    logic              overflow_q, overflow_d;
    logic              push_req, push_ok, pop, full, empty;

    assign push_req = enable && (mode == MODE_ALL || !last_valid_q || result_in != last_value_q);
    assign pop      = rd_valid && rd_ready;
    assign push_ok  = push_req && (!full || pop);
    assign rd_valid = !empty;
    assign overflow = overflow_q;

    // A dropped capture leaves last_value alone so the next change still registers.
    always_comb begin
        cyc_d        = clear ? '0 : cyc_q + CYC_W'(enable);
        last_valid_d = clear ? 1'b0 : (last_valid_q || push_ok);
        last_value_d = (push_ok && !clear) ? result_in : last_value_q;
        overflow_d   = clear ? 1'b0 : (overflow_q || (push_req && !push_ok));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q        <= '0;
            last_value_q <= '0;
            last_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cyc_q        <= cyc_d;
            last_value_q <= last_value_d;
            last_valid_q <= last_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (CYC_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .push_i  (push_req),
        .pop_i   (pop),
        .wdata_i ({cyc_q, result_in}),
        .rdata_o ({rd_cycle, rd_data}),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

endmodule

// File: tb/tb_result_trace_buffer.sv
// tb_result_trace_buffer: table-driven directed checks plus hand sequences for wrap and async reset.
module tb_result_trace_buffer;

    typedef struct packed {
        logic        en;
        logic        md;
        logic        clr;
        logic        rr;
        logic [31:0] res;
        logic        ev;
        logic [31:0] ed;
        logic [15:0] ec;
        logic [4:0]  ecnt;
        logic        eo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0, mode = 1'b0, clear = 1'b0, rd_ready = 1'b0;
    logic [31:0] result_in = '0;

    logic        rd_valid, overflow, rd_valid2, overflow2;
    logic [31:0] rd_data, rd_data2;
    logic [15:0] rd_cycle;
    logic [3:0]  rd_cycle2;
    logic [4:0]  count;
    logic [2:0]  count2;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    result_trace_buffer #(.DATA_W(32), .DEPTH(16), .CYC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .clear(clear),
        .result_in(result_in), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_cycle(rd_cycle), .count(count), .overflow(overflow)
    );

    // Small instance for counter wrap and overflow with a shallow FIFO.
    result_trace_buffer #(.DATA_W(32), .DEPTH(4), .CYC_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .clear(clear),
        .result_in(result_in), .rd_valid(rd_valid2), .rd_ready(rd_ready),
        .rd_data(rd_data2), .rd_cycle(rd_cycle2), .count(count2), .overflow(overflow2)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic vec_t v(input logic en, input logic md, input logic clr, input logic rr,
                               input int res, input logic ev, input int ed, input int ec,
                               input int cnt, input logic eo);
        vec_t x;
        x.en = en; x.md = md; x.clr = clr; x.rr = rr; x.res = res;
        x.ev = ev; x.ed = ed; x.ec = 16'(ec); x.ecnt = 5'(cnt); x.eo = eo;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int idx, input vec_t x);
        enable = x.en; mode = x.md; clear = x.clr; rd_ready = x.rr; result_in = x.res;
        step();
        chk($sformatf("row%0d valid", idx), rd_valid, x.ev);
        chk($sformatf("row%0d count", idx), count, x.ecnt);
        chk($sformatf("row%0d overflow", idx), overflow, x.eo);
        if (x.ev) begin
            chk($sformatf("row%0d data", idx), rd_data, x.ed);
            chk($sformatf("row%0d cycle", idx), rd_cycle, x.ec);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // capture every cycle, then drain
        vq.push_back(v(1,0,0,0,5, 1,5,0,1,0));
        vq.push_back(v(1,0,0,0,6, 1,5,0,2,0));
        vq.push_back(v(1,0,0,0,7, 1,5,0,3,0));
        vq.push_back(v(0,0,0,1,0, 1,6,1,2,0));
        vq.push_back(v(0,0,0,1,0, 1,7,2,1,0));
        vq.push_back(v(0,0,0,1,0, 0,0,0,0,0));
        // capture on change
        vq.push_back(v(0,0,1,0,0, 0,0,0,0,0));
        vq.push_back(v(1,1,0,0,9, 1,9,0,1,0));
        for (int i = 0; i < 3; i++) vq.push_back(v(1,1,0,0,9, 1,9,0,1,0));
        for (int i = 0; i < 2; i++) vq.push_back(v(1,1,0,0,12, 1,9,0,2,0));
        vq.push_back(v(0,1,0,1,0, 1,12,4,1,0));
        vq.push_back(v(0,1,0,1,0, 0,0,0,0,0));
        // fill past full, push+pop while full, drain
        vq.push_back(v(0,0,1,0,0, 0,0,0,0,0));
        for (int i = 0; i < 20; i++)
            vq.push_back(v(1,0,0,0,100+i, 1,100,0, (i < 16) ? i+1 : 16, i >= 16));
        vq.push_back(v(1,0,0,1,200, 1,101,1,16,1));
        for (int j = 0; j < 16; j++)
            vq.push_back(v(0,0,0,1,0, j < 15, (j < 14) ? 102+j : 200, (j < 14) ? j+2 : 20, 15-j, 1));
        // clear beats push and pop
        vq.push_back(v(0,0,1,0,0, 0,0,0,0,0));
        for (int i = 0; i < 8; i++) vq.push_back(v(1,0,0,0,300+i, 1,300,0,i+1,0));
        vq.push_back(v(1,0,1,1,999, 0,0,0,0,0));
        vq.push_back(v(1,0,0,0,400, 1,400,0,1,0));

        #2;
        chk("reset valid", rd_valid, 0);
        chk("reset data", rd_data, 0);
        chk("reset cycle", rd_cycle, 0);
        chk("reset count", count, 0);
        chk("reset overflow", overflow, 0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) run(i, vq[i]);

        // 4-bit stamp wrap with continuous drain on the small instance
        enable = 0; clear = 1; rd_ready = 0;
        step();
        clear = 0; mode = 0; enable = 1; rd_ready = 1;
        for (int i = 0; i < 18; i++) begin
            result_in = 500 + i;
            step();
            chk($sformatf("wrap%0d valid", i), rd_valid2, 1);
            chk($sformatf("wrap%0d cycle", i), rd_cycle2, i % 16);
            chk($sformatf("wrap%0d data", i), rd_data2, 500 + i);
            chk($sformatf("wrap%0d count", i), count2, 1);
            chk($sformatf("wrap%0d overflow", i), overflow2, 0);
        end
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold%0d count", i), count2, 0);
        end
        enable = 1; rd_ready = 0; result_in = 600;
        step();
        chk("frozen cycle", rd_cycle2, 2);
        chk("frozen count", count2, 1);

        // async reset mid-cycle with count=5
        enable = 0; clear = 1;
        step();
        clear = 0; enable = 1;
        for (int i = 0; i < 5; i++) begin
            result_in = 700 + i;
            step();
        end
        enable = 0;
        chk("pre-reset count", count, 5);
        chk("pre-reset overflow2", overflow2, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async valid", rd_valid, 0);
        chk("async data", rd_data, 0);
        chk("async cycle", rd_cycle, 0);
        chk("async count", count, 0);
        chk("async overflow", overflow, 0);
        chk("async overflow2", overflow2, 0);
        #2 rst_n = 1'b1;
        enable = 1; result_in = 77;
        step();
        enable = 0;
        chk("resume valid", rd_valid, 1);
        chk("resume data", rd_data, 77);
        chk("resume cycle", rd_cycle, 0);
        chk("resume count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
